// File: rtl/rst_sequencer.sv
// Releases per-domain active-low resets in index order after system reset or a
// soft-reset request, with a programmable gap between consecutive releases.
module rst_sequencer #(
  parameter int NUM_DOMAINS = 3,
  parameter int CNT_WIDTH   = 8,
  parameter int HOLD_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   RST,
  input  logic                   SW_RST_REQ,
  input  logic [CNT_WIDTH-1:0]   GAP_CFG,
  output logic [NUM_DOMAINS-1:0] SEQ_RST_N,
  output logic                   SW_RST_ACK,
  output logic                   SEQ_DONE,
  output logic [1:0]             SEQ_STATE
);

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int IDX_W  = $clog2(NUM_DOMAINS + 1);

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } state_t;

  state_t                 state, state_nxt;
  logic [HOLD_W-1:0]      hold_cnt, hold_cnt_nxt;
  logic [CNT_WIDTH-1:0]   gap_cnt, gap_cnt_nxt;
  logic [CNT_WIDTH-1:0]   gap_q, gap_q_nxt;
  logic [IDX_W-1:0]       idx, idx_nxt;
  logic [NUM_DOMAINS-1:0] seq_rst_n_nxt;
  logic                   req_d;
  logic                   ack_nxt;
  logic                   done_nxt;
  logic                   req_rise;

  assign req_rise = SW_RST_REQ & ~req_d;

  // A soft request pre-empts any release scheduled on the same edge.
  always_comb begin
    state_nxt     = state;
    hold_cnt_nxt  = hold_cnt;
    gap_cnt_nxt   = gap_cnt;
    gap_q_nxt     = gap_q;
    idx_nxt       = idx;
    seq_rst_n_nxt = SEQ_RST_N;
    ack_nxt       = 1'b0;
    done_nxt      = (state == RUN);
    if (req_rise) begin
      state_nxt     = HOLD;
      hold_cnt_nxt  = '0;
      gap_cnt_nxt   = '0;
      idx_nxt       = '0;
      seq_rst_n_nxt = '0;
      ack_nxt       = 1'b1;
      done_nxt      = 1'b0;
    end else begin
      unique case (state)
        HOLD: begin
          if (hold_cnt == HOLD_W'(HOLD_CYCLES - 1)) begin
            seq_rst_n_nxt[0] = 1'b1;
            gap_q_nxt        = GAP_CFG;
            gap_cnt_nxt      = '0;
            idx_nxt          = IDX_W'(1);
            hold_cnt_nxt     = '0;
            state_nxt        = (NUM_DOMAINS == 1) ? RUN : RELEASE;
          end else begin
            hold_cnt_nxt = hold_cnt + 1'b1;
          end
        end
        RELEASE: begin
          if (gap_cnt == gap_q) begin
            seq_rst_n_nxt[idx] = 1'b1;
            gap_cnt_nxt        = '0;
            idx_nxt            = idx + 1'b1;
            if (idx == IDX_W'(NUM_DOMAINS - 1)) state_nxt = RUN;
          end else begin
            gap_cnt_nxt = gap_cnt + 1'b1;
          end
        end
        RUN: seq_rst_n_nxt = '1;
        default: state_nxt = HOLD;
      endcase
    end
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state      <= HOLD;
      hold_cnt   <= '0;
      gap_cnt    <= '0;
      idx        <= '0;
      req_d      <= 1'b0;
      SEQ_RST_N  <= '0;
      SW_RST_ACK <= 1'b0;
      SEQ_DONE   <= 1'b0;
    end else begin
      state      <= state_nxt;
      hold_cnt   <= hold_cnt_nxt;
      gap_cnt    <= gap_cnt_nxt;
      idx        <= idx_nxt;
      req_d      <= SW_RST_REQ;
      SEQ_RST_N  <= seq_rst_n_nxt;
      SW_RST_ACK <= ack_nxt;
      SEQ_DONE   <= done_nxt;
    end
  end

  // Gap value is only consumed after it is written on leaving HOLD.
  always_ff @(posedge clk) begin
    gap_q <= gap_q_nxt;
  end

  assign SEQ_STATE = state;

endmodule
